decode_cycle: RTL and testbench
===============================

DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 The module SHALL have no parameters; all data widths SHALL be fixed at 32 bits and register indices at 5 bits.
REQ-002 The ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- InstrD  in  32  instruction from fetch.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RegWriteW  in  1  write-back enable.
- RDW  in  5  write-back destination index.
- ResultW  in  32  write-back data.
- StallD  in  1  hold the ID/EX register.
- FlushE  in  1  insert a bubble into the ID/EX register.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE  out  1 each  registered controls.
- ResultSrcE  out  2  result select: 00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32  registered data.
- Rs1E, Rs2E, RdE  out  5  registered register indices.

Function
REQ-003 Decode SHALL be combinational from InstrD, and all outputs SHALL be registered, giving exactly one cycle of latency from InstrD to the E outputs.
REQ-004 Supported opcodes SHALL be:
- 0000011 lw
- 0100011 sw
- 0110011 R-type
- 0010011 I-ALU
- 1100011 beq
- 1101111 jal
REQ-005 Control SHALL be:
- lw: RegWrite=1, ALUSrc=1, ResultSrc=01.
- sw: MemWrite=1, ALUSrc=1.
- R-type and I-ALU: RegWrite=1, ResultSrc=00; ALUSrc=1 for I-ALU only.
- beq: Branch=1, ALUControl=001.
- jal: Jump=1, RegWrite=1, ResultSrc=10.
REQ-006 ALU decode SHALL map funct3 as follows: 000 gives add, or sub when R-type with funct7[5]=1; 010 gives slt; 110 gives or; 111 gives and; lw, sw and jal SHALL use add.
REQ-007 Any unsupported opcode or funct3 SHALL produce all-zero controls with IllegalE=1.
REQ-008 Immediates SHALL be sign-extended from bit 31:
- I: [31:20]
- S: {[31:25],[11:7]}
- B: {[31],[7],[30:25],[11:8],0}
- J: {[31],[19:12],[20],[30:21],0}
- R-type: ImmExt=0.
REQ-009 The register file SHALL be 32x32; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-010 Writes SHALL occur on the rising clk edge when RegWriteW=1 and RDW!=0.
REQ-011 Rs1=InstrD[19:15], Rs2=InstrD[24:20] and Rd=InstrD[11:7] SHALL pass through to Rs1E, Rs2E and RdE regardless of opcode.
REQ-012 With StallD=1 and FlushE=0, the ID/EX register SHALL hold its current contents; register-file writes SHALL still occur.
REQ-013 With FlushE=1, every control output and IllegalE SHALL load 0 on the next edge, and the data fields SHALL load 0; FlushE SHALL override StallD.
REQ-014 Priority SHALL be rst > FlushE > StallD > normal load.

Reset
REQ-015 While rst=0 at a rising edge, every output SHALL load 0 and all 32 registers SHALL clear to 0.
REQ-016 A write-back presented in the same cycle that rst=0 SHALL be discarded.
REQ-017 Reset asserted mid-stream SHALL discard the in-flight instruction, and the first edge with rst=1 SHALL load the current InstrD normally.
REQ-018 There SHALL be no asynchronous reset path.

Configuration
REQ-019 The macro RF_WRITE_BYPASS_EN SHALL be the only configuration control.
REQ-020 With RF_WRITE_BYPASS_EN defined, a read of a register being written in the same cycle (RegWriteW=1, RDW==Rs, RDW!=0) SHALL return ResultW, so the ID/EX register captures the new value.
REQ-021 Without RF_WRITE_BYPASS_EN, that read SHALL return the old register contents, and the new value SHALL be visible from the following cycle.

Verification
REQ-022 InstrD=0x00500093 (addi x1,x0,5) SHALL produce, after one edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=0x00000005, RdE=1, RD1E=0, IllegalE=0.
REQ-023 InstrD=0xFE000CE3 (beq x0,x0,-8) with PCD=0x100 SHALL produce BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, PCE=0x100, PCPlus4E=0x104.
REQ-024 Write-back of x5=0xDEADBEEF in the same cycle as InstrD=0x00028033 (add x0,x5,x0) SHALL give RD1E=0xDEADBEEF with RF_WRITE_BYPASS_EN and RD1E=0 without it; a write of 0x1234 to x0 SHALL leave later reads of x0 at 0.
REQ-025 Asserting StallD for 2 cycles while InstrD changes SHALL hold all E outputs constant; asserting StallD=1 and FlushE=1 together SHALL zero all controls on the next edge.
REQ-026 Pulsing rst=0 for 1 cycle mid-stream SHALL zero all outputs and the register file (reading x5 afterwards returns 0), and applying InstrD=0x0000007F afterwards SHALL give IllegalE=1 with all controls 0.

Source files
------------

// File: rtl/decode_cycle.sv
// decode_cycle: instruction decode stage with register file and ID/EX register.
//
// Decodes InstrD combinationally (controls, ALU operation, immediate, register
// reads) and captures everything in the ID/EX register, so the E outputs
// follow InstrD by exactly one clock.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-low reset
//   InstrD, PCD, PCPlus4D   instruction and its PCs from fetch
//   RegWriteW, RDW, ResultW write-back port into the register file
//   StallD              hold the ID/EX register
//   FlushE              load a bubble (all zero) into the ID/EX register
//   *E outputs          registered controls, data and register indices
//
// Configuration:
//   RF_WRITE_BYPASS_EN  when defined, a read of the register being written in
//                       the same cycle returns ResultW instead of the old value.

module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        StallD,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic        IllegalE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE
);

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpIAlu = 7'b0010011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign rd       = InstrD[11:7];

    // Decoded (pre-register) controls.
    logic        regWrite;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic        aluSrc;
    logic        illegal;
    logic [1:0]  resultSrc;
    logic [2:0]  aluControl;
    logic [31:0] immExt;

    // ALU-op decode shared by R-type and I-ALU.
    logic       aluLegal;
    logic [2:0] aluOp;

    always_comb begin
        aluLegal = 1'b1;
        aluOp    = AluAdd;
        case (funct3)
            3'b000:  aluOp = (opcode == OpR && funct7b5) ? AluSub : AluAdd;
            3'b010:  aluOp = AluSlt;
            3'b110:  aluOp = AluOr;
            3'b111:  aluOp = AluAnd;
            default: aluLegal = 1'b0;
        endcase
    end

    always_comb begin
        regWrite   = 1'b0;
        memWrite   = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        aluSrc     = 1'b0;
        illegal    = 1'b0;
        resultSrc  = 2'b00;
        aluControl = AluAdd;
        immExt     = 32'h0;
        case (opcode)
            OpLw: begin
                if (funct3 == 3'b010) begin
                    regWrite  = 1'b1;
                    aluSrc    = 1'b1;
                    resultSrc = 2'b01;
                    immExt    = {{20{InstrD[31]}}, InstrD[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OpSw: begin
                if (funct3 == 3'b010) begin
                    memWrite = 1'b1;
                    aluSrc   = 1'b1;
                    immExt   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OpR: begin
                if (aluLegal) begin
                    regWrite   = 1'b1;
                    aluControl = aluOp;
                end else begin
                    illegal = 1'b1;
                end
            end
            OpIAlu: begin
                if (aluLegal) begin
                    regWrite   = 1'b1;
                    aluSrc     = 1'b1;
                    aluControl = aluOp;
                    immExt     = {{20{InstrD[31]}}, InstrD[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OpBeq: begin
                if (funct3 == 3'b000) begin
                    branch     = 1'b1;
                    aluControl = AluSub;
                    immExt     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                                  InstrD[11:8], 1'b0};
                end else begin
                    illegal = 1'b1;
                end
            end
            OpJal: begin
                jump      = 1'b1;
                regWrite  = 1'b1;
                resultSrc = 2'b10;
                immExt    = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                             InstrD[30:21], 1'b0};
            end
            default: illegal = 1'b1;
        endcase
    end

    // Register file: x0 is never written and always reads as zero.
    logic [31:0] rf [32];
    logic [31:0] rd1;
    logic [31:0] rd2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'h0;
            end
        end else if (RegWriteW && RDW != 5'd0) begin
            rf[RDW] <= ResultW;
        end
    end

    always_comb begin
        rd1 = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
        rd2 = (rs2 == 5'd0) ? 32'h0 : rf[rs2];
`ifdef RF_WRITE_BYPASS_EN
        if (RegWriteW && RDW != 5'd0 && RDW == rs1) rd1 = ResultW;
        if (RegWriteW && RDW != 5'd0 && RDW == rs2) rd2 = ResultW;
`endif
    end

    // ID/EX register: reset and flush both load an all-zero bubble.
    always_ff @(posedge clk) begin
        if (!rst || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            IllegalE    <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            RD1E        <= 32'h0;
            RD2E        <= 32'h0;
            ImmExtE     <= 32'h0;
            PCE         <= 32'h0;
            PCPlus4E    <= 32'h0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
        end else if (!StallD) begin
            RegWriteE   <= regWrite;
            MemWriteE   <= memWrite;
            JumpE       <= jump;
            BranchE     <= branch;
            ALUSrcE     <= aluSrc;
            IllegalE    <= illegal;
            ResultSrcE  <= resultSrc;
            ALUControlE <= aluControl;
            RD1E        <= rd1;
            RD2E        <= rd2;
            ImmExtE     <= immExt;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            Rs1E        <= rs1;
            Rs2E        <= rs2;
            RdE         <= rd;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed self-checking bench for decode_cycle.
// Inputs change #1 after a rising edge; outputs are sampled at the same point.

module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        StallD;
    logic        FlushE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic        IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;

    int checks   = 0;
    int failures = 0;

    decode_cycle dut (
        .clk        (clk),
        .rst        (rst),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .RegWriteW  (RegWriteW),
        .RDW        (RDW),
        .ResultW    (ResultW),
        .StallD     (StallD),
        .FlushE     (FlushE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .JumpE      (JumpE),
        .BranchE    (BranchE),
        .ALUSrcE    (ALUSrcE),
        .IllegalE   (IllegalE),
        .ResultSrcE (ResultSrcE),
        .ALUControlE(ALUControlE),
        .RD1E       (RD1E),
        .RD2E       (RD2E),
        .ImmExtE    (ImmExtE),
        .PCE        (PCE),
        .PCPlus4E   (PCPlus4E),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE)
    );

    always #5 clk = ~clk;

    // Controls packed as {RegWrite, MemWrite, Jump, Branch, ALUSrc, Illegal, ResultSrc, ALUControl}.
    logic [10:0] ctrl;
    assign ctrl = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE,
                   ResultSrcE, ALUControlE};

    // OR of every data field, zero only when all of them are zero.
    logic [31:0] dataOr;
    assign dataOr = RD1E | RD2E | ImmExtE | PCE | PCPlus4E | {17'h0, Rs1E, Rs2E, RdE};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        InstrD   = instr;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
    endtask

    task automatic wb(input logic we, input logic [4:0] idx, input logic [31:0] val);
        RegWriteW = we;
        RDW       = idx;
        ResultW   = val;
    endtask

    initial begin
        // Reset with a pending write-back to x5, which must be discarded.
        rst    = 1'b0;
        StallD = 1'b0;
        FlushE = 1'b0;
        drive(32'h0052F1B3, 32'h0000_0040);
        wb(1'b1, 5'd5, 32'hAAAA_5555);
        step();
        step();
        check("reset_ctrl", 32'(ctrl), 32'h0);
        check("reset_data", dataOr, 32'h0);

        // addi x1,x0,5
        rst = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        drive(32'h00500093, 32'h0000_0000);
        step();
        check("addi_ctrl", 32'(ctrl), 32'h440);
        check("addi_imm", ImmExtE, 32'h5);
        check("addi_rd", 32'(RdE), 32'd1);
        check("addi_rd1", RD1E, 32'h0);

        // x5 must still be zero: the write-back during reset was dropped.
        drive(32'h00028033, 32'h0000_0004);
        step();
        check("rst_wb_dropped", RD1E, 32'h0);
        check("radd_rs1", 32'(Rs1E), 32'd5);

        // beq x0,x0,-8 at PC 0x100
        drive(32'hFE000CE3, 32'h0000_0100);
        step();
        check("beq_ctrl", 32'(ctrl), 32'h081);
        check("beq_imm", ImmExtE, 32'hFFFF_FFF8);
        check("beq_pc", PCE, 32'h100);
        check("beq_pc4", PCPlus4E, 32'h104);

        // Same-cycle write of x5 while reading it.
        drive(32'h00028033, 32'h0000_0108);
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
`ifdef RF_WRITE_BYPASS_EN
        check("bypass_rd1", RD1E, 32'hDEAD_BEEF);
`else
        check("nobypass_rd1", RD1E, 32'h0);
`endif
        wb(1'b0, 5'd0, 32'h0);
        step();
        check("x5_after_write", RD1E, 32'hDEAD_BEEF);

        // Write to x0 is discarded, both same-cycle and later.
        drive(32'h00000033, 32'h0000_010C);
        wb(1'b1, 5'd0, 32'h0000_1234);
        step();
        check("x0_same_cycle", RD1E, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        step();
        check("x0_later", RD1E | RD2E, 32'h0);

        // sub x3,x5,x5
        drive(32'h405281B3, 32'h0000_0110);
        step();
        check("sub_ctrl", 32'(ctrl), 32'h401);
        check("sub_rd2", RD2E, 32'hDEAD_BEEF);
        check("sub_imm", ImmExtE, 32'h0);
        check("sub_rd", 32'(RdE), 32'd3);

        // lw x6,-4(x5)
        drive(32'hFFC2A303, 32'h0000_0114);
        step();
        check("lw_ctrl", 32'(ctrl), 32'h448);
        check("lw_imm", ImmExtE, 32'hFFFF_FFFC);

        // sw x5,8(x0)
        drive(32'h00502423, 32'h0000_0118);
        step();
        check("sw_ctrl", 32'(ctrl), 32'h240);
        check("sw_imm", ImmExtE, 32'h8);
        check("sw_rd2", RD2E, 32'hDEAD_BEEF);

        // jal x1,+16
        drive(32'h010000EF, 32'h0000_011C);
        step();
        check("jal_ctrl", 32'(ctrl), 32'h510);
        check("jal_imm", ImmExtE, 32'h10);

        // slti x2,x1,-1 / ori x2,x1,-1 / and x3,x5,x5 / illegal R funct3 001
        drive(32'hFFF0A113, 32'h0000_0120);
        step();
        check("slti_ctrl", 32'(ctrl), 32'h445);
        check("slti_imm", ImmExtE, 32'hFFFF_FFFF);
        drive(32'hFFF0E113, 32'h0000_0124);
        step();
        check("ori_ctrl", 32'(ctrl), 32'h443);
        drive(32'h0052F1B3, 32'h0000_0128);
        step();
        check("and_ctrl", 32'(ctrl), 32'h402);
        drive(32'h005291B3, 32'h0000_012C);
        step();
        check("bad_funct3_ctrl", 32'(ctrl), 32'h020);
        check("bad_funct3_rd", 32'(RdE), 32'd3);

        // Stall two cycles with changing InstrD; write-back of x7 continues.
        drive(32'h00500093, 32'h0000_0200);
        step();
        StallD = 1'b1;
        drive(32'hFE000CE3, 32'h0000_0300);
        wb(1'b1, 5'd7, 32'h0000_0077);
        step();
        drive(32'h010000EF, 32'h0000_0400);
        wb(1'b0, 5'd0, 32'h0);
        step();
        check("stall_ctrl", 32'(ctrl), 32'h440);
        check("stall_imm", ImmExtE, 32'h5);
        check("stall_pc", PCE, 32'h200);

        // Flush overrides stall.
        FlushE = 1'b1;
        step();
        check("flush_ctrl", 32'(ctrl), 32'h0);
        check("flush_data", dataOr, 32'h0);

        // x7 written during the stall.
        StallD = 1'b0;
        FlushE = 1'b0;
        drive(32'h00038033, 32'h0000_0500);
        step();
        check("stall_wb_x7", RD1E, 32'h77);

        // Mid-stream reset pulse.
        drive(32'h010000EF, 32'h0000_0600);
        step();
        rst = 1'b0;
        drive(32'h00028033, 32'h0000_0604);
        step();
        check("midrst_ctrl", 32'(ctrl), 32'h0);
        check("midrst_data", dataOr, 32'h0);
        rst = 1'b1;
        step();
        check("post_rst_load", 32'(ctrl), 32'h400);
        check("post_rst_x5", RD1E, 32'h0);
        check("post_rst_pc", PCE, 32'h604);
        drive(32'h0000007F, 32'h0000_0608);
        step();
        check("illegal_op_ctrl", 32'(ctrl), 32'h020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
